// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and filters PS2C/PS2D, deframes 11-bit
// frames and forwards make codes only (E0 prefixes and F0-xx releases dropped).
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [7:0] DATO,
  output logic       FLAG,
  output logic       PAR_ERR,
  output logic       FRM_ERR
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic [FILTER_LEN-1:0] flt_q, flt_d;
  logic                  fclk_q, fclk_d;
  state_t                state_q, state_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [7:0]            sh_q, sh_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  brk_q, brk_d;
  logic [7:0]            dato_q, dato_d;
  logic                  flag_q, flag_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  smp;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      flt_q    <= '1;
      fclk_q   <= 1'b1;
      state_q  <= IDLE;
      bcnt_q   <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      brk_q    <= 1'b0;
      dato_q   <= '0;
      flag_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      c_meta_q <= PS2C;
      c_sync_q <= c_meta_q;
      d_meta_q <= PS2D;
      d_sync_q <= d_meta_q;
      flt_q    <= flt_d;
      fclk_q   <= fclk_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      brk_q    <= brk_d;
      dato_q   <= dato_d;
      flag_q   <= flag_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    flt_d  = {flt_q[FILTER_LEN-2:0], c_sync_q};
    fclk_d = fclk_q;
    if (flt_q == '0) begin
      fclk_d = 1'b0;
    end else if (&flt_q) begin
      fclk_d = 1'b1;
    end
    // Strobe is the cycle in which the filtered clock is about to fall.
    smp = fclk_q && (flt_q == '0);
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    brk_d   = brk_q;
    dato_d  = dato_q;
    flag_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    tmo_d   = (smp || state_q == IDLE) ? '0 : tmo_q + TW'(1);

    if (smp) begin
      case (state_q)
        IDLE: begin
          if (!d_sync_q) begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          sh_d   = {d_sync_q, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = d_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A framing error masks a simultaneous parity error.
          if (!d_sync_q) begin
            ferr_d = 1'b1;
          end else if (!odd_parity_ok(sh_q, par_q)) begin
            perr_d = 1'b1;
          end else if (sh_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (sh_q != 8'hE0) begin
            if (brk_q) begin
              brk_d = 1'b0;
            end else begin
              dato_d = sh_q;
              flag_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      ferr_d  = 1'b1;
      state_d = IDLE;
    end
  end

  assign DATO    = dato_q;
  assign FLAG    = flag_q;
  assign PAR_ERR = perr_q;
  assign FRM_ERR = ferr_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: table of frames with hand-derived outcomes feeding a
// scoreboard queue, plus glitch, timeout and mid-frame reset sequences.
module tb_ps2_scan_rx;

  localparam int FL  = 8;
  localparam int TMO = 400;
  localparam int H   = 25;

  localparam logic [1:0] EV_NONE = 2'd0;
  localparam logic [1:0] EV_FLAG = 2'd1;
  localparam logic [1:0] EV_PAR  = 2'd2;
  localparam logic [1:0] EV_FRM  = 2'd3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic [7:0] DATO;
  logic       FLAG, PAR_ERR, FRM_ERR;

  always #5 CLK = ~CLK;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2C(PS2C), .PS2D(PS2D),
    .DATO(DATO), .FLAG(FLAG), .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR)
  );

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         stop;
    logic [1:0] kind;
    logic [7:0] dato;
  } vec_t;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] dato;
  } ev_t;

  ev_t        sbq[$];
  vec_t       vecs[15];
  int         n_checks = 0;
  int         n_errs = 0;
  logic [7:0] last_dato = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] code);
    ev_t e;
    if (kind == EV_NONE) return;
    if (kind == EV_FLAG) last_dato = code;
    e.kind = kind;
    e.dato = last_dato;
    sbq.push_back(e);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] c, input bit bad, input bit stop);
    logic p;
    p = (~^c) ^ bad;
    return {stop, p, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2D = bits[i];
      repeat (H) @(posedge CLK);
      PS2C = 1'b0;
      repeat (H) @(posedge CLK);
      PS2C = 1'b1;
    end
    PS2D = 1'b1;
  endtask

  task automatic settle_check(input string tag);
    chk({tag, "_pending"}, sbq.size(), 0);
    chk({tag, "_dato"}, DATO, last_dato);
  endtask

  initial begin
    vecs[0]  = '{8'h43, 0, 1, EV_FLAG, 8'h43};
    vecs[1]  = '{8'h5A, 1, 1, EV_PAR,  8'h00};
    vecs[2]  = '{8'h1C, 0, 1, EV_FLAG, 8'h1C};
    vecs[3]  = '{8'hF0, 0, 1, EV_NONE, 8'h00};
    vecs[4]  = '{8'h1C, 0, 1, EV_NONE, 8'h00};
    vecs[5]  = '{8'h33, 0, 1, EV_FLAG, 8'h33};
    vecs[6]  = '{8'hE0, 0, 1, EV_NONE, 8'h00};
    vecs[7]  = '{8'h2D, 0, 1, EV_FLAG, 8'h2D};
    vecs[8]  = '{8'h2D, 0, 1, EV_FLAG, 8'h2D};
    vecs[9]  = '{8'h44, 1, 0, EV_FRM,  8'h00};
    vecs[10] = '{8'hF0, 0, 1, EV_NONE, 8'h00};
    vecs[11] = '{8'h55, 1, 1, EV_PAR,  8'h00};
    vecs[12] = '{8'h55, 0, 1, EV_NONE, 8'h00};
    vecs[13] = '{8'h66, 0, 1, EV_FLAG, 8'h66};
    vecs[14] = '{8'h00, 0, 0, EV_FRM,  8'h00};

    fork
      begin : monitor
        forever begin
          ev_t        e;
          logic [1:0] k;
          @(negedge CLK);
          if (FLAG || PAR_ERR || FRM_ERR) begin
            k = FLAG ? EV_FLAG : (PAR_ERR ? EV_PAR : EV_FRM);
            chk("one_hot_pulse", $countones({FLAG, PAR_ERR, FRM_ERR}), 1);
            if (sbq.size() == 0) begin
              n_checks++;
              n_errs++;
              $display("FAIL unexpected_pulse: got kind %0d dato %0h, required no pulse", k, DATO);
            end else begin
              e = sbq.pop_front();
              chk("event_kind", k, e.kind);
              chk("event_dato", DATO, e.dato);
            end
          end
        end
      end
    join_none

    repeat (5) @(posedge CLK);
    #1;
    chk("rst_dato", DATO, 8'h00);
    chk("rst_flag", FLAG, 1'b0);
    chk("rst_par", PAR_ERR, 1'b0);
    chk("rst_frm", FRM_ERR, 1'b0);
    @(negedge CLK) RST_N = 1'b1;
    repeat (5) @(posedge CLK);

    // Table frames, sent back to back.
    for (int i = 0; i < 15; i++) begin
      expect_ev(vecs[i].kind, vecs[i].dato);
      send_bits(frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop), 11);
      settle_check($sformatf("vec%0d", i));
    end
    repeat (20) @(posedge CLK);

    // Short low glitch on PS2C while idle, then a frame with a bad stop bit.
    PS2C = 1'b0;
    repeat (FL - 2) @(posedge CLK);
    PS2C = 1'b1;
    repeat (40) @(posedge CLK);
    settle_check("glitch");
    expect_ev(EV_FRM, 8'h00);
    send_bits(frame(8'h12, 0, 0), 11);
    settle_check("stop0");

    // Stall after four data bits until the timeout fires.
    expect_ev(EV_FRM, 8'h00);
    send_bits(frame(8'hA5, 0, 1), 5);
    repeat (TMO + 40) @(posedge CLK);
    settle_check("timeout");
    expect_ev(EV_FLAG, 8'h35);
    send_bits(frame(8'h35, 0, 1), 11);
    settle_check("after_tmo");

    // Reset in the middle of a frame.
    send_bits(frame(8'h77, 0, 1), 4);
    PS2D = 1'b0;
    repeat (H) @(posedge CLK);
    PS2C = 1'b0;
    repeat (15) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_dato", DATO, 8'h00);
    chk("midrst_flag", FLAG, 1'b0);
    chk("midrst_par", PAR_ERR, 1'b0);
    chk("midrst_frm", FRM_ERR, 1'b0);
    last_dato = 8'h00;
    PS2C = 1'b1;
    PS2D = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    repeat (20) @(posedge CLK);
    settle_check("post_rst");
    expect_ev(EV_FLAG, 8'h4B);
    send_bits(frame(8'h4B, 0, 1), 11);
    settle_check("after_rst");

    repeat (20) @(posedge CLK);
    chk("final_pending", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
